hd_similarity_search: RTL and testbench

Associative-search back end of the HD accelerator: once the encoder has written a complete query hypervector into query memory, this block streams it chunk by chunk against every class hypervector in class memory. It accumulates one signed dot product per class and reports the arg-max class and its score. It sits downstream of the encoding controller and is started by that controller's completion.

---
 rtl/hd_similarity_search_pkg.sv | 21 ++
 rtl/hd_similarity_search_if.sv | 28 ++
 rtl/hd_similarity_search_chunk_dot_product.sv | 27 ++
 rtl/hd_similarity_search.sv | 144 ++++++++++++++
 tb/tb_hd_similarity_search.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/hd_similarity_search_pkg.sv
// Shared configuration, state encoding and word types for the HD associative-search back end.
package hd_pkg;

   localparam int DHV_SIZE    = 4000;
   localparam int CHUNK_ELEMS = 16;
   localparam int ELEM_WIDTH  = 16;
   localparam int N_CLASSES   = 26;
   localparam int ACC_WIDTH   = 48;
   localparam int QADDR_WIDTH = 8;
   localparam int CADDR_WIDTH = 13;

   localparam int NUM_CHUNKS  = DHV_SIZE / CHUNK_ELEMS;
   localparam int TOTAL       = N_CLASSES * NUM_CHUNKS;
   localparam int CLASS_W     = $clog2(N_CLASSES);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   // One memory word: CHUNK_ELEMS signed elements, element 0 in the low bits.
   typedef logic signed [CHUNK_ELEMS-1:0][ELEM_WIDTH-1:0] chunk_t;

endpackage

// File: rtl/hd_similarity_search_if.sv
// Control handshake plus query/class memory read bus of the similarity search.
interface hd_similarity_search_if;
   import hd_pkg::*;

   logic                          start;
   logic                          busy;
   logic                          result_valid;
   logic [CLASS_W-1:0]            pred_class;
   logic signed [ACC_WIDTH-1:0]   pred_score;
   logic [QADDR_WIDTH-1:0]        query_addr;
   chunk_t                        query_data;
   logic [CADDR_WIDTH-1:0]        class_addr;
   chunk_t                        class_data;
   logic                          mem_rd_en;

   modport slave (
      input  start, query_data, class_data,
      output busy, result_valid, pred_class, pred_score,
             query_addr, class_addr, mem_rd_en
   );

   modport master (
      output start, query_data, class_data,
      input  busy, result_valid, pred_class, pred_score,
             query_addr, class_addr, mem_rd_en
   );

endinterface

// File: rtl/hd_similarity_search_chunk_dot_product.sv
// Combinational signed dot product of two memory words, sign-extended to the accumulator width.
module chunk_dot_product #(
   parameter int CHUNK_ELEMS = 16,
   parameter int ELEM_WIDTH  = 16,
   parameter int ACC_WIDTH   = 48
) (
   input  logic [CHUNK_ELEMS-1:0][ELEM_WIDTH-1:0] a,
   input  logic [CHUNK_ELEMS-1:0][ELEM_WIDTH-1:0] b,
   output logic signed [ACC_WIDTH-1:0]            dot
);

   logic signed [2*ELEM_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    sum;

   // Multiply every lane and sum the sign-extended products; synthesis balances the sum into a tree.
   always_comb begin
      prod = '0;
      sum  = '0;
      for (int i = 0; i < CHUNK_ELEMS; i++) begin
         prod = $signed(a[i]) * $signed(b[i]);
         sum  = sum + ACC_WIDTH'(prod);
      end
   end

   assign dot = sum;

endmodule

// File: rtl/hd_similarity_search.sv
// Streams the query hypervector against every class hypervector and reports the arg-max class.
// Pipeline: issue address -> memory word returns -> accumulate chunk -> compare finished class.
module hd_similarity_search
   import hd_pkg::*;
(
   input logic                    clk,
   input logic                    reset_in,
   hd_similarity_search_if.slave  bus
);

   state_t                      state_q, state_d;
   logic [QADDR_WIDTH-1:0]      qaddr_q, qaddr_d;
   logic [CADDR_WIDTH-1:0]      caddr_q, caddr_d;
   logic [CLASS_W-1:0]          cls_q, cls_d;
   logic                        rd_en_q, rd_en_d;

   logic                        s1_valid_q, s1_valid_d;
   logic                        s1_first_q, s1_first_d;
   logic                        s1_last_q, s1_last_d;
   logic [CLASS_W-1:0]          s1_cls_q, s1_cls_d;

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        cmp_valid_q, cmp_valid_d;
   logic [CLASS_W-1:0]          cmp_cls_q, cmp_cls_d;

   logic [CLASS_W-1:0]          best_cls_q, best_cls_d;
   logic signed [ACC_WIDTH-1:0] best_score_q, best_score_d;

   logic signed [ACC_WIDTH-1:0] chunk_dot;

   chunk_dot_product #(
      .CHUNK_ELEMS (CHUNK_ELEMS),
      .ELEM_WIDTH  (ELEM_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
   ) u_dot (
      .a   (bus.query_data),
      .b   (bus.class_data),
      .dot (chunk_dot)
   );

   // Sequencer: walks class-outer/chunk-inner addresses and tracks the search phase.
   always_comb begin
      state_d = state_q;
      qaddr_d = qaddr_q;
      caddr_d = caddr_q;
      cls_d   = cls_q;
      rd_en_d = rd_en_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = SCAN;
               qaddr_d = '0;
               caddr_d = '0;
               cls_d   = '0;
               rd_en_d = 1'b1;
            end
         end
         SCAN: begin
            if (caddr_q == CADDR_WIDTH'(TOTAL - 1)) begin
               state_d = DRAIN;
               rd_en_d = 1'b0;
            end else begin
               caddr_d = caddr_q + CADDR_WIDTH'(1);
               if (qaddr_q == QADDR_WIDTH'(NUM_CHUNKS - 1)) begin
                  qaddr_d = '0;
                  cls_d   = cls_q + CLASS_W'(1);
               end else begin
                  qaddr_d = qaddr_q + QADDR_WIDTH'(1);
               end
            end
         end
         DRAIN: begin
            if (cmp_valid_q && (cmp_cls_q == CLASS_W'(N_CLASSES - 1))) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: tag the returning word, accumulate per class, keep the first-highest class score.
   always_comb begin
      s1_valid_d   = rd_en_q;
      s1_first_d   = (qaddr_q == '0);
      s1_last_d    = (qaddr_q == QADDR_WIDTH'(NUM_CHUNKS - 1));
      s1_cls_d     = cls_q;
      acc_d        = acc_q;
      cmp_valid_d  = s1_valid_q && s1_last_q;
      cmp_cls_d    = s1_cls_q;
      best_cls_d   = best_cls_q;
      best_score_d = best_score_q;
      if (s1_valid_q) begin
         acc_d = s1_first_q ? chunk_dot : acc_q + chunk_dot;
      end
      if (cmp_valid_q && ((cmp_cls_q == '0) || (acc_q > best_score_q))) begin
         best_cls_d   = cmp_cls_q;
         best_score_d = acc_q;
      end
   end

   // State, pipeline and result registers; reset discards any partial search.
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state_q      <= IDLE;
         qaddr_q      <= '0;
         caddr_q      <= '0;
         cls_q        <= '0;
         rd_en_q      <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_first_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_cls_q     <= '0;
         acc_q        <= '0;
         cmp_valid_q  <= 1'b0;
         cmp_cls_q    <= '0;
         best_cls_q   <= '0;
         best_score_q <= '0;
      end else begin
         state_q      <= state_d;
         qaddr_q      <= qaddr_d;
         caddr_q      <= caddr_d;
         cls_q        <= cls_d;
         rd_en_q      <= rd_en_d;
         s1_valid_q   <= s1_valid_d;
         s1_first_q   <= s1_first_d;
         s1_last_q    <= s1_last_d;
         s1_cls_q     <= s1_cls_d;
         acc_q        <= acc_d;
         cmp_valid_q  <= cmp_valid_d;
         cmp_cls_q    <= cmp_cls_d;
         best_cls_q   <= best_cls_d;
         best_score_q <= best_score_d;
      end
   end

   assign bus.query_addr   = qaddr_q;
   assign bus.class_addr   = caddr_q;
   assign bus.mem_rd_en    = rd_en_q;
   assign bus.busy         = (state_q == SCAN) || (state_q == DRAIN);
   assign bus.result_valid = (state_q == DONE);
   assign bus.pred_class   = best_cls_q;
   assign bus.pred_score   = best_score_q;

endmodule

// File: tb/tb_hd_similarity_search.sv
// Scoreboard bench for hd_similarity_search with a one-cycle-latency memory model.
module tb_hd_similarity_search;
   import hd_pkg::*;

   typedef struct {
      int     cls;
      longint score;
      string  name;
   } exp_t;

   logic   clk;
   logic   reset_in;
   int     cyc;
   int     start_cyc;
   int     checks;
   int     errors;
   int     pattern;
   int     q_val;
   exp_t   exp_q[$];

   int     trace_item;
   int     trace_bad;
   logic   prev_busy;
   logic   prev_rv;

   hd_similarity_search_if bus_if ();

   hd_similarity_search dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus_if)
   );

   // Free-running clock and edge counter used for latency measurement.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic chunk_t fill_word(input int v);
      chunk_t w;
      w = '0;
      for (int e = 0; e < CHUNK_ELEMS; e++) w[e] = ELEM_WIDTH'(v);
      return w;
   endfunction

   function automatic int class_value(input logic [CADDR_WIDTH-1:0] addr);
      int k;
      k = int'(addr) / NUM_CHUNKS;
      case (pattern)
         0:       return k;
         1:       return ((k == 3) || (k == 7)) ? 5 : 1;
         default: return -(k + 1);
      endcase
   endfunction

   // Query and class memories: every element of a word holds the same value, read latency one cycle.
   always @(posedge clk) begin
      bus_if.query_data <= fill_word(q_val);
      bus_if.class_data <= fill_word(class_value(bus_if.class_addr));
   end

   task automatic check_output(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: follows the address trace and checks each finished search against the scoreboard.
   initial begin
      trace_item = 0;
      trace_bad  = 0;
      prev_busy  = 1'b0;
      prev_rv    = 1'b0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus_if.busy && !prev_busy) begin
         trace_item = 0;
         trace_bad  = 0;
      end
      if (bus_if.mem_rd_en) begin
         if ((int'(bus_if.query_addr) != trace_item % NUM_CHUNKS) ||
             (int'(bus_if.class_addr) != trace_item)) begin
            trace_bad++;
         end
         trace_item++;
      end
      if (bus_if.result_valid && !prev_rv) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_output({e.name, "_class"}, longint'(bus_if.pred_class), e.cls);
            check_output({e.name, "_score"}, longint'($signed(bus_if.pred_score)), e.score);
            check_output({e.name, "_latency"}, cyc - start_cyc, TOTAL + 2);
            check_output({e.name, "_addr_errors"}, trace_bad, 0);
            check_output({e.name, "_items"}, trace_item, TOTAL);
         end
      end
      prev_busy = bus_if.busy;
      prev_rv   = bus_if.result_valid;
   end

   // Issues an accepted start; optionally queues the result expected from it.
   task automatic apply_stimulus(input int exp_cls, input longint exp_score,
                                 input string name, input bit expect_it);
      logic was_valid;
      exp_t e;
      @(negedge clk);
      was_valid = bus_if.result_valid;
      bus_if.start = 1'b1;
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
      start_cyc = cyc;
      if (expect_it) begin
         e.cls   = exp_cls;
         e.score = exp_score;
         e.name  = name;
         exp_q.push_back(e);
      end
      check_output({name, "_busy_at_start"}, longint'(bus_if.busy), 1);
      if (was_valid) check_output({name, "_rv_drop"}, longint'(bus_if.result_valid), 0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus_if.start = 1'b1;
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
   endtask

   task automatic wait_result(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus_if.result_valid && n < TOTAL + 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus_if.result_valid) check_output({name, "_timeout"}, 0, 1);
      @(negedge clk);
   endtask

   // Directed sequence: reset, ascending, tie, negative classes, ignored starts, abort and restart.
   initial begin
      checks       = 0;
      errors       = 0;
      start_cyc    = 0;
      pattern      = 0;
      q_val        = 1;
      reset_in     = 1'b1;
      bus_if.start = 1'b0;

      #2 reset_in = 1'b0;
      #1;
      check_output("reset_busy", longint'(bus_if.busy), 0);
      check_output("reset_result_valid", longint'(bus_if.result_valid), 0);
      #10 reset_in = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] ascending classes");
      pattern = 0; q_val = 1;
      apply_stimulus(25, 100000, "ascending", 1'b1);
      wait_result("ascending");

      $display("[TB] tie between classes 3 and 7");
      pattern = 1; q_val = 1;
      apply_stimulus(3, 20000, "tie", 1'b1);
      wait_result("tie");

      $display("[TB] all-negative classes");
      pattern = 2; q_val = 1;
      apply_stimulus(0, -4000, "neg_pos_query", 1'b1);
      wait_result("neg_pos_query");
      q_val = -1;
      apply_stimulus(25, 104000, "neg_neg_query", 1'b1);
      wait_result("neg_neg_query");

      $display("[TB] starts during scan are ignored");
      pattern = 0; q_val = 1;
      apply_stimulus(25, 100000, "ignored_starts", 1'b1);
      repeat (98) @(negedge clk);
      pulse_start();
      repeat (2898) @(negedge clk);
      pulse_start();
      wait_result("ignored_starts");

      $display("[TB] abort mid-scan and restart");
      pattern = 1; q_val = 1;
      apply_stimulus(0, 0, "aborted", 1'b0);
      repeat (2999) @(negedge clk);
      #2 reset_in = 1'b0;
      #1;
      check_output("abort_busy", longint'(bus_if.busy), 0);
      check_output("abort_rd_en", longint'(bus_if.mem_rd_en), 0);
      check_output("abort_query_addr", longint'(bus_if.query_addr), 0);
      check_output("abort_class_addr", longint'(bus_if.class_addr), 0);
      check_output("abort_pred_class", longint'(bus_if.pred_class), 0);
      check_output("abort_pred_score", longint'($signed(bus_if.pred_score)), 0);
      repeat (2) @(negedge clk);
      reset_in = 1'b1;
      apply_stimulus(3, 20000, "restart", 1'b1);
      wait_result("restart");

      check_output("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
